// File: rtl/bank_sequencer.sv
// rtl/bank_sequencer.sv - feeds one line of digits into a long_stack, drains the kept digits into a line value and running total.
// Optional input checking (sticky err) is built only when AOC3_SEQ_ERR_CHECK_EN is defined.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bank_sequencer #(
  parameter int MAX_CAP   = 12,
  parameter int LINE_LEN  = 100,
  parameter int SUM_WIDTH = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_digit,
  input  logic                         in_last,
  output logic                         stk_valid,
  output logic [`DATA_WIDTH-1:0]       stk_data,
  output logic [`DATA_WIDTH-1:0]       stk_nums_left,
  output logic [$clog2(MAX_CAP):0]     stk_peek,
  input  logic [`DATA_WIDTH-1:0]       stk_data_out,
  output logic                         stk_clear,
  output logic                         line_done,
  output logic [SUM_WIDTH-1:0]         line_value,
  output logic [SUM_WIDTH-1:0]         total,
  output logic                         err
);

  localparam int CNT_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int PEEK_W = $clog2(MAX_CAP) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_LEN - 1);
  localparam logic [PEEK_W-1:0] PEEK_LAST = PEEK_W'(MAX_CAP - 1);

  typedef enum logic [1:0] {
    FEED,
    DRAIN,
    CLEAR
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SUM_WIDTH-1:0] acc;
  logic                 accept;
  logic                 last_digit;

  assign in_ready      = (state == FEED) && !reset;
  assign stk_valid     = in_valid && in_ready;
  assign accept        = stk_valid;
  assign last_digit    = (cnt == CNT_LAST);
  assign stk_data      = `DATA_WIDTH'(in_digit);
  assign stk_nums_left = `DATA_WIDTH'(LINE_LEN) - `DATA_WIDTH'(cnt);
  assign stk_clear     = reset | (state == CLEAR);

  // Line boundaries come from the digit count alone; in_last only feeds the optional checker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FEED;
      cnt        <= '0;
      acc        <= '0;
      stk_peek   <= '0;
      line_value <= '0;
      total      <= '0;
      line_done  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        FEED: begin
          if (accept) begin
            if (last_digit) begin
              state    <= DRAIN;
              cnt      <= '0;
              acc      <= '0;
              stk_peek <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          acc <= acc * SUM_WIDTH'(10) + SUM_WIDTH'(stk_data_out);
          if (stk_peek == PEEK_LAST) begin
            state    <= CLEAR;
            stk_peek <= '0;
          end else begin
            stk_peek <= stk_peek + 1'b1;
          end
        end
        CLEAR: begin
          line_value <= acc;
          total      <= total + acc;
          line_done  <= 1'b1;
          state      <= FEED;
        end
        default: state <= FEED;
      endcase
    end
  end

`ifdef AOC3_SEQ_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && ((in_last != last_digit) || (in_digit > 4'd9))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_in_last;

  assign unused_in_last = in_last;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_bank_sequencer.sv
// tb/tb_bank_sequencer.sv - directed bench for bank_sequencer with a behavioural long_stack model.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_bank_sequencer;

  localparam int MAX_CAP   = 12;
  localparam int LINE_LEN  = 15;
  localparam int SUM_WIDTH = 64;

`ifdef AOC3_SEQ_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [3:0]               in_digit = 4'd0;
  logic                     in_last = 1'b0;
  logic                     stk_valid;
  logic [`DATA_WIDTH-1:0]   stk_data;
  logic [`DATA_WIDTH-1:0]   stk_nums_left;
  logic [$clog2(MAX_CAP):0] stk_peek;
  logic [`DATA_WIDTH-1:0]   stk_data_out;
  logic                     stk_clear;
  logic                     line_done;
  logic [SUM_WIDTH-1:0]     line_value;
  logic [SUM_WIDTH-1:0]     total;
  logic                     err;

  bank_sequencer #(
    .MAX_CAP  (MAX_CAP),
    .LINE_LEN (LINE_LEN),
    .SUM_WIDTH(SUM_WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_digit     (in_digit),
    .in_last      (in_last),
    .stk_valid    (stk_valid),
    .stk_data     (stk_data),
    .stk_nums_left(stk_nums_left),
    .stk_peek     (stk_peek),
    .stk_data_out (stk_data_out),
    .stk_clear    (stk_clear),
    .line_done    (line_done),
    .line_value   (line_value),
    .total        (total),
    .err          (err)
  );

  initial forever #5 clock = ~clock;

  // Greedy largest-subsequence stack: pop smaller tops while enough digits remain to refill.
  logic [`DATA_WIDTH-1:0] stk_mem [0:MAX_CAP-1];
  int stk_sz = 0;

  assign stk_data_out = (int'(stk_peek) < MAX_CAP) ? stk_mem[stk_peek] : '0;

  initial forever begin
    @(posedge clock);
    if (stk_clear) begin
      stk_sz = 0;
    end else if (stk_valid) begin
      while (stk_sz > 0 && stk_mem[stk_sz-1] < stk_data &&
             (stk_sz - 1 + int'(stk_nums_left)) >= MAX_CAP)
        stk_sz--;
      if (stk_sz < MAX_CAP) begin
        stk_mem[stk_sz] = stk_data;
        stk_sz++;
      end
    end
  end

  longint unsigned got_q [$];
  int              run_q [$];
  int              lo_run = 0;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      lo_run = 0;
    end else begin
      if (line_done) got_q.push_back(line_value);
      if (!in_ready) lo_run++;
      else if (lo_run > 0) begin
        run_q.push_back(lo_run);
        lo_run = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int digs  [0:63];
  bit lasts [0:63];

  task automatic load_line(input int base, input string s);
    for (int i = 0; i < LINE_LEN; i++) begin
      digs[base+i]  = int'(s[i]) - 48;
      lasts[base+i] = (i == LINE_LEN - 1);
    end
  endtask

  task automatic feed(input int n, input int duty);
    int budget;
    bit taken;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      taken  = 1'b0;
      while (!taken) begin
        @(negedge clock);
        in_valid = ($urandom_range(99) < duty);
        in_digit = 4'(digs[i]);
        in_last  = lasts[i];
        taken    = in_valid && in_ready;
        budget++;
        if (budget > 200) begin
          check("feed_timeout", 64'd0, 64'd1);
          return;
        end
        @(posedge clock);
      end
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clock);
      k++;
      #1;
    end while (!line_done && k < 100);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  localparam logic [63:0] V1 = 64'd987654321111;
  localparam logic [63:0] V2 = 64'd811111111119;
  localparam logic [63:0] V3 = 64'd434234234278;
  localparam logic [63:0] V4 = 64'd888911112111;
  localparam logic [63:0] VT = 64'd3121910778619;

  initial begin
    int k;
    logic [63:0] exp_v [0:3];
    exp_v[0] = V1; exp_v[1] = V2; exp_v[2] = V3; exp_v[3] = V4;

    // reset state, with in_valid high to show it is not accepted
    in_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_stk_valid", stk_valid, 1'b0);
    check("rst_stk_clear", stk_clear, 1'b1);
    check("rst_line_value", line_value, 64'd0);
    check("rst_total", total, 64'd0);
    check("rst_line_done", line_done, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_stk_clear", stk_clear, 1'b0);
    check("idle_peek", stk_peek, 64'd0);
    check("idle_nums_left", stk_nums_left, 64'd15);

    // single line and its latency
    load_line(0, "987654321111111");
    feed(LINE_LEN, 100);
    #1 in_valid = 1'b0;
    wait_done(k);
    check("lat_line1", k, 64'd13);
    check("line1_value", line_value, V1);
    check("line1_total", total, V1);
    check("line1_in_ready", in_ready, 1'b1);

    // three lines with in_valid held high throughout
    load_line(0, "811111111111119");
    load_line(15, "234234234234278");
    load_line(30, "818181911112111");
    @(negedge clock);
    got_q.delete();
    run_q.delete();
    feed(3 * LINE_LEN, 100);
    #1 in_valid = 1'b0;
    wait_done(k);
    @(negedge clock);
    #1;
    check("cont_lines", got_q.size(), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("cont_value%0d", i), got_q[i], exp_v[i+1]);
    check("cont_total", total, VT);
    check("cont_runs", run_q.size(), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("cont_run%0d", i), run_q[i], 64'd13);

    // reset in the middle of DRAIN
    load_line(0, "987654321111111");
    feed(LINE_LEN, 100);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("drain_peek5", stk_peek, 64'd5);
    in_valid = 1'b1;
    #1;
    check("drain_stk_valid", stk_valid, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_line_value", line_value, 64'd0);
    check("midrst_total", total, 64'd0);
    check("midrst_stk_clear", stk_clear, 1'b1);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_peek", stk_peek, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    feed(LINE_LEN, 100);
    #1 in_valid = 1'b0;
    wait_done(k);
    check("postrst_value", line_value, V1);
    check("postrst_total", total, V1);

    // early in_last on digit 10
    load_line(0, "987654321111111");
    lasts[9] = 1'b1;
    feed(LINE_LEN, 100);
    #1 in_valid = 1'b0;
    check("err_early_last", err, EXP_ERR);
    wait_done(k);
    check("err_line_value", line_value, V1);
    load_line(0, "987654321111111");
    feed(LINE_LEN, 100);
    #1 in_valid = 1'b0;
    wait_done(k);
    check("err_sticky", err, EXP_ERR);
    check("err_line2_total", total, 64'd3 * V1);

    // four lines with a 50% in_valid duty after a fresh reset
    do_reset();
    load_line(0, "987654321111111");
    load_line(15, "811111111111119");
    load_line(30, "234234234234278");
    load_line(45, "818181911112111");
    got_q.delete();
    run_q.delete();
    feed(4 * LINE_LEN, 50);
    #1 in_valid = 1'b0;
    wait_done(k);
    @(negedge clock);
    #1;
    check("rand_lines", got_q.size(), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rand_value%0d", i), got_q[i], exp_v[i]);
    check("rand_total", total, VT);
    check("rand_runs", run_q.size(), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rand_run%0d", i), run_q[i], 64'd13);
    check("rand_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bank_sequencer.md
BANK_SEQUENCER -- requirements
Module: bank_sequencer

Interface
REQ-001 SHALL have parameter MAX_CAP, default 12: digits kept per line, matching the attached long_stack.
REQ-002 SHALL have parameter LINE_LEN, default 100: digits per line; LINE_LEN >= MAX_CAP.
REQ-003 SHALL have parameter SUM_WIDTH, default 64: width of line value and running total.
REQ-004 SHALL have these ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  in_digit valid.
- in_ready  out  1  sequencer accepts a digit this cycle.
- in_digit  in  4  decimal digit 0..9.
- in_last  in  1  upstream marks the final digit of a line.
- stk_valid  out  1  drives stack data_in_valid.
- stk_data  out  `DATA_WIDTH  drives stack data_in; in_digit zero-extended.
- stk_nums_left  out  `DATA_WIDTH  drives stack nums_left.
- stk_peek  out  $clog2(MAX_CAP)+1  drives stack peek_i.
- stk_data_out  in  `DATA_WIDTH  stack data_out, combinational from stk_peek.
- stk_clear  out  1  drives stack synchronous reset.
- line_done  out  1  one-cycle pulse; line_value/total updated.
- line_value  out  SUM_WIDTH  value of the most recent line.
- total  out  SUM_WIDTH  sum of all line values since reset.
- err  out  1  sticky input error flag; see Configuration.

Function
REQ-005 SHALL implement states FEED, DRAIN and CLEAR.
REQ-006 FEED SHALL drive in_ready=1; DRAIN and CLEAR SHALL drive in_ready=0.
REQ-007 A digit SHALL be accepted when in_valid && in_ready; stk_valid SHALL equal in_valid && in_ready combinationally.
REQ-008 stk_nums_left SHALL be LINE_LEN - cnt, where cnt is the number of digits already accepted in the line, 0..LINE_LEN-1.
REQ-009 SHALL increment cnt on each accepted digit.
REQ-010 On acceptance with cnt==LINE_LEN-1, SHALL go to DRAIN, clear cnt to 0, clear acc to 0 and set stk_peek=0.
REQ-011 End of line SHALL be determined only by cnt; in_last SHALL NOT change sequencing.
REQ-012 DRAIN SHALL last exactly MAX_CAP cycles.
REQ-013 On DRAIN cycle k (k=0..MAX_CAP-1), SHALL drive stk_peek=k and register acc <= acc*10 + stk_data_out.
REQ-014 The acc*10 + stk_data_out update SHALL be truncated modulo 2^SUM_WIDTH.
REQ-015 After DRAIN cycle MAX_CAP-1, SHALL go to CLEAR.
REQ-016 CLEAR SHALL last one cycle, assert stk_clear=1 and register line_value <= acc and total <= total + acc (modulo 2^SUM_WIDTH).
REQ-017 CLEAR SHALL then go to FEED, and line_done SHALL be 1 for exactly the first FEED cycle.
REQ-018 Latency SHALL be: edge accepting the last digit, then MAX_CAP+1 cycles with in_ready=0, then line_done=1 with in_ready=1.
REQ-019 stk_clear SHALL equal reset | (state==CLEAR), combinationally.
REQ-020 stk_peek SHALL be 0 outside DRAIN.
REQ-021 in_valid during DRAIN or CLEAR SHALL be ignored without loss; upstream holds the digit until in_ready.
REQ-022 A line_done cycle that also accepts a digit SHALL count that digit as cnt=0 of the next line.

Reset
REQ-023 Asserting reset SHALL immediately set state=FEED, cnt=0, acc=0, line_value=0, total=0, err=0 and line_done=0, including mid-line or mid-DRAIN.
REQ-024 While reset is high, SHALL hold in_ready=0 and stk_valid=0.
REQ-025 The first digit after reset deassertion SHALL be cnt=0.

Configuration
REQ-026 With macro AOC3_SEQ_ERR_CHECK_EN defined, SHALL set err sticky on an accepted digit with in_last=1 and cnt!=LINE_LEN-1.
REQ-027 With AOC3_SEQ_ERR_CHECK_EN defined, SHALL set err sticky on an accepted digit with in_last=0 and cnt==LINE_LEN-1.
REQ-028 With AOC3_SEQ_ERR_CHECK_EN defined, SHALL set err sticky on an accepted digit with in_digit>9.
REQ-029 With AOC3_SEQ_ERR_CHECK_EN defined, sequencing SHALL be unchanged by err, and only reset SHALL clear err.
REQ-030 Without AOC3_SEQ_ERR_CHECK_EN, err SHALL be tied 0 and no check logic SHALL be present.

Verification
REQ-031 Bench (LINE_LEN=15, MAX_CAP=12, real long_stack attached): line 987654321111111 -> line_value=987654321111, line_done exactly 13 cycles after the last-digit edge.
REQ-032 Lines 811111111111119, 234234234234278, 818181911112111 after REQ-031 -> line_value 811111111119, 434234234278, 888911112111; total=3121910778619.
REQ-033 in_valid held high continuously across REQ-032 -> no digit dropped or duplicated; in_ready low exactly 13 cycles per line.
REQ-034 Reset asserted at DRAIN cycle 5 -> outputs zero at once, stk_clear=1; the next full line 987654321111111 -> line_value=987654321111, total=987654321111.
REQ-035 With AOC3_SEQ_ERR_CHECK_EN defined: in_last=1 on digit 10 -> err=1 and stays 1, and line_value is still produced after digit 15; without the macro, the same stimulus -> err=0.
REQ-036 in_valid random 50% duty over 4 lines -> results identical to REQ-032.
